cmov_words_param: RTL and testbench
===================================

Name: cmov_words_param

Overview:
- Parametrised constant-time conditional move for the coprocessor data memory: copies word_count words to dst_base.
- Each destination word is src1 when the latched flag is 1, else src0.
- Both sources are always read and merged through a full-width mask, so address trace, cycle count and write pattern are independent of the flag.
- Successor to the fixed 4-word, base-select cmov: adds programmable count, three base addresses, configurable read latency and a start/busy/done handshake.

Parameters:
DATA_W, 64, memory word width
ADDR_W, 9, memory address width
CNT_W, 9, width of word_count
RD_LAT, 1, memory read latency in cycles (read_data valid RD_LAT cycles after read_address); legal 1..4

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  one-cycle request, accepted only in IDLE
flag  input  1  move condition, sampled with start
src0_base  input  ADDR_W  base of source 0 (taken when flag=0)
src1_base  input  ADDR_W  base of source 1 (taken when flag=1)
dst_base  input  ADDR_W  destination base
word_count  input  CNT_W  number of words N, sampled with start
read_address  output  ADDR_W  memory read address
read_data  input  DATA_W  memory read data
write_address  output  ADDR_W  memory write address
write_data  output  DATA_W  memory write data
write_en  output  1  memory write strobe
busy  output  1  high from the cycle after start acceptance until done
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. read_address, write_address, write_data = 0; write_en, busy, done = 0; mask and counters cleared.
- Cycle 0 (IDLE, start=1): latch bases and N. Latch mask = {DATA_W{flag}}. Go to RD.
- start while not IDLE: ignored. flag or base changes after cycle 0: no effect.
- States: IDLE -> RD -> DRAIN -> DONE -> IDLE.
- RD, cycles k = 1..2N:
  - odd k: read_address = src0_base + i
  - even k: read_address = src1_base + i
  - i = (k-1)/2; sums are modulo 2^ADDR_W (wrap-around).
- Tag pipeline: an RD_LAT-deep shift register carries {valid, src_sel, i}.
- Capture:
  - src0 tag emerging (cycle 2i+1+RD_LAT): register d0 = read_data.
  - src1 tag emerging (cycle 2i+2+RD_LAT): register write_data = (d0 & ~mask) | (read_data & mask); write_address = dst_base + i (mod 2^ADDR_W); write_en = 1 the following cycle only.
- Write timing: writes at cycles 2i+3+RD_LAT, one every other cycle, exactly N writes regardless of flag.
- DRAIN: entered after cycle 2N; waits until the tag pipeline is empty and the last write has issued (cycle 2N+1+RD_LAT).
- DONE: done=1 for exactly one cycle at cycle 2N+2+RD_LAT, then IDLE. busy=1 for cycles 1..2N+1+RD_LAT.
- N=0: no reads, no writes; busy low; done pulses at cycle 1; return to IDLE.
- Outside active read cycles read_address holds 0. write_address and write_data are valid only when write_en=1.
- Overlapping source/destination regions are not detected. Reads of word i complete before the write of word i; the caller guarantees dst does not overwrite unread source words.
- Total cycle count from start to done depends only on N and RD_LAT, never on flag or data.
- Reset mid-operation: immediate return to IDLE; no further write_en; no done pulse.

Test Plan:
- N=4, RD_LAT=1, src0 at 0x000 = {0x11..,0x22..,0x33..,0x44..}, src1 at 0x010 = {0xAA..,0xBB..,0xCC..,0xDD..}, dst=0x020, flag=0 -> dst words equal src0 values; done at cycle 11; 8 reads, 4 writes.
- Same memory contents, flag=1 -> dst equals src1 values. Read-address trace, write-address trace and done cycle identical to the flag=0 run.
- N=0 -> no write_en, busy stays low, done high at cycle 1. Then N=1 run: 1 write at cycle 4, done at cycle 5.
- RD_LAT=3, N=3, flag=1, src1_base=0x1FE -> reads wrap to 0x1FE, 0x1FF, 0x000. Writes at cycles 6, 8, 10; done at cycle 11.
- N=8 run, flag toggled every cycle and start re-pulsed during busy -> result follows the flag latched at cycle 0, no second operation, single done.
- N=8 run, rst asserted low at cycle 6 -> all outputs 0 immediately, no write_en afterwards, no done. A new start after release completes normally.

Source files
------------

// File: rtl/cmov_words_param.sv
// Constant-time conditional word move: both sources are always read and merged
// through a flag-derived mask, so the address and write traces never depend on the flag.
module cmov_words_param #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 9,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flag,
  input  logic [ADDR_W-1:0] src0_base,
  input  logic [ADDR_W-1:0] src1_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [CNT_W-1:0]  word_count,
  output logic [ADDR_W-1:0] read_address,
  input  logic [DATA_W-1:0] read_data,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  output logic              write_en,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD    = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                        state_q, state_d;
  logic [ADDR_W-1:0]             src0_q, src0_d, src1_q, src1_d, dst_q, dst_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [DATA_W-1:0]             mask_q, mask_d;
  logic                          rd_act_q, rd_act_d, rd_sel_q, rd_sel_d;
  logic [CNT_W-1:0]              rd_idx_q, rd_idx_d;
  logic [ADDR_W-1:0]             rd_addr_q, rd_addr_d;
  logic [RD_LAT-1:0]             tag_v_q, tag_v_d, tag_s_q, tag_s_d;
  logic [RD_LAT-1:0][CNT_W-1:0]  tag_i_q, tag_i_d;
  logic [DATA_W-1:0]             d0_q, d0_d, wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]             wr_addr_q, wr_addr_d;
  logic                          wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d;

  // Next-state logic: read sequencing, tag pipeline, capture/merge and FSM
  always_comb begin
    state_d   = state_q;
    src0_d    = src0_q;
    src1_d    = src1_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    rd_act_d  = rd_act_q;
    rd_sel_d  = rd_sel_q;
    rd_idx_d  = rd_idx_q;
    rd_addr_d = rd_addr_q;
    d0_d      = d0_q;
    wr_data_d = wr_data_q;
    wr_addr_d = wr_addr_q;
    wr_en_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;

    // Stage 0 records the read presented this cycle; the last stage lines up with read_data.
    tag_v_d    = tag_v_q;
    tag_s_d    = tag_s_q;
    tag_i_d    = tag_i_q;
    tag_v_d[0] = rd_act_q;
    tag_s_d[0] = rd_sel_q;
    tag_i_d[0] = rd_idx_q;
    for (int j = 1; j < RD_LAT; j++) begin
      tag_v_d[j] = tag_v_q[j-1];
      tag_s_d[j] = tag_s_q[j-1];
      tag_i_d[j] = tag_i_q[j-1];
    end

    if (tag_v_q[RD_LAT-1]) begin
      if (!tag_s_q[RD_LAT-1]) begin
        d0_d = read_data;
      end else begin
        wr_data_d = (d0_q & ~mask_q) | (read_data & mask_q);
        wr_addr_d = dst_q + ADDR_W'(tag_i_q[RD_LAT-1]);
        wr_en_d   = 1'b1;
      end
    end else begin
      d0_d = d0_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src0_d = src0_base;
          src1_d = src1_base;
          dst_d  = dst_base;
          cnt_d  = word_count;
          mask_d = {DATA_W{flag}};
          if (word_count == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = S_RD;
            busy_d    = 1'b1;
            rd_act_d  = 1'b1;
            rd_sel_d  = 1'b0;
            rd_idx_d  = '0;
            rd_addr_d = src0_base;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (!rd_sel_q) begin
          rd_sel_d  = 1'b1;
          rd_addr_d = src1_q + ADDR_W'(rd_idx_q);
        end else if (rd_idx_q == cnt_q - CNT_W'(1)) begin
          rd_act_d  = 1'b0;
          rd_sel_d  = 1'b0;
          rd_addr_d = '0;
          state_d   = S_DRAIN;
        end else begin
          rd_sel_d  = 1'b0;
          rd_idx_d  = rd_idx_q + CNT_W'(1);
          rd_addr_d = src0_q + ADDR_W'(rd_idx_q + CNT_W'(1));
        end
      end
      S_DRAIN: begin
        // The pipeline empties exactly in the cycle the final write is on the bus.
        if (tag_v_q == '0) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      src0_q    <= '0;
      src1_q    <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      mask_q    <= '0;
      rd_act_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      rd_idx_q  <= '0;
      rd_addr_q <= '0;
      tag_v_q   <= '0;
      tag_s_q   <= '0;
      tag_i_q   <= '0;
      d0_q      <= '0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src0_q    <= src0_d;
      src1_q    <= src1_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      rd_act_q  <= rd_act_d;
      rd_sel_q  <= rd_sel_d;
      rd_idx_q  <= rd_idx_d;
      rd_addr_q <= rd_addr_d;
      tag_v_q   <= tag_v_d;
      tag_s_q   <= tag_s_d;
      tag_i_q   <= tag_i_d;
      d0_q      <= d0_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign read_address  = rd_addr_q;
  assign write_address = wr_addr_q;
  assign write_data    = wr_data_q;
  assign write_en      = wr_en_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_cmov_words_param.sv
// Bench for cmov_words_param: one instance at read latency 1 and one at latency 3,
// driven from a record table, with expected writes queued and compared as they appear.
module tb_cmov_words_param;
  localparam int DW = 64;
  localparam int AW = 9;
  localparam int CW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          flag = 1'b0;
  logic [AW-1:0] src0_base = '0, src1_base = '0, dst_base = '0;
  logic [CW-1:0] word_count = '0;
  logic [AW-1:0] ra1, wa1, ra3, wa3;
  logic [DW-1:0] rd1, rd3, wd1, wd3;
  logic          we1, we3, busy1, busy3, done1, done3;

  always #5 clk = ~clk;

  // Read-only memory model with per-instance read latency
  logic [DW-1:0] mem [0:511];
  logic [AW-1:0] rp1 = '0;
  logic [AW-1:0] rp3 [0:2] = '{default: '0};
  always @(posedge clk) begin
    rp1    <= ra1;
    rp3[0] <= ra3;
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign rd1 = mem[rp1];
  assign rd3 = mem[rp3[2]];

  cmov_words_param #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .flag(flag),
    .src0_base(src0_base), .src1_base(src1_base), .dst_base(dst_base),
    .word_count(word_count), .read_address(ra1), .read_data(rd1),
    .write_address(wa1), .write_data(wd1), .write_en(we1), .busy(busy1), .done(done1));

  cmov_words_param #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .flag(flag),
    .src0_base(src0_base), .src1_base(src1_base), .dst_base(dst_base),
    .word_count(word_count), .read_address(ra3), .read_data(rd3),
    .write_address(wa3), .write_data(wd3), .write_en(we3), .busy(busy3), .done(done3));

  typedef struct {
    logic          flg;
    logic [AW-1:0] s0, s1, d;
    int            n;
    bit            tog;
    int            rst_at;
    int            done1, done3;
  } rec_t;

  typedef struct {
    int            cyc;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  rec_t recs [8];
  rec_t cur;
  wr_t  q1[$], q3[$];
  int   errors = 0, checks = 0;
  int   cyc = 0, t0 = 0;
  int   dcnt1 = 0, dcnt3 = 0;
  bit   mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int rel, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s rel_cycle=%0d got=%0h expected=%0h", nm, rel, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] exp_ra(input int rel);
    if (cur.n > 0 && rel >= 1 && rel <= 2 * cur.n && !(cur.rst_at != 0 && rel >= cur.rst_at))
      return ((rel % 2 == 1) ? cur.s0 : cur.s1) + AW'((rel - 1) / 2);
    return '0;
  endfunction

  task automatic mon(input int L, input int rel, input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                     input logic [DW-1:0] wd, input logic we, input logic bsy, input logic dn);
    logic eb;
    int   ed;
    wr_t  e;
    bit   have;
    eb = (cur.n > 0 && rel >= 1 && rel <= 2 * cur.n + 1 + L && !(cur.rst_at != 0 && rel >= cur.rst_at));
    ed = (L == 1) ? cur.done1 : cur.done3;
    check($sformatf("read_addr_L%0d", L), rel, 128'(ra), 128'(exp_ra(rel)));
    check($sformatf("busy_L%0d", L), rel, 128'(bsy), 128'(eb));
    check($sformatf("done_L%0d", L), rel, 128'(dn), 128'(rel == ed));
    if (dn) begin
      if (L == 1) dcnt1++; else dcnt3++;
    end
    if (cur.rst_at != 0 && rel >= cur.rst_at && rel <= cur.rst_at + 1)
      check($sformatf("rst_zero_L%0d", L), rel, 128'({wa, wd, we}), 128'(0));
    if (we) begin
      have = (L == 1) ? (q1.size() > 0) : (q3.size() > 0);
      if (!have) begin
        check($sformatf("unexpected_write_L%0d", L), rel, 128'(wa), 128'(0));
        errors += (wa == '0) ? 1 : 0;
      end else begin
        if (L == 1) e = q1.pop_front(); else e = q3.pop_front();
        check($sformatf("write_L%0d", L), rel, {32'(rel), 23'(wa), wd}, {32'(e.cyc), 23'(e.a), e.d});
      end
    end
  endtask

  // Per-cycle monitor of both instances, sampled away from the active edge
  always @(negedge clk) begin
    if (mon_on) begin
      mon(1, cyc - t0, ra1, wa1, wd1, we1, busy1, done1);
      mon(3, cyc - t0, ra3, wa3, wd3, we3, busy3, done3);
    end
  end

  initial begin
    int  len;
    wr_t e;
    for (int a = 0; a < 512; a++) mem[a] = 64'h9E3779B97F4A7C15 * 64'(a + 1);
    mem[0]  = 64'h1111111111111111;  mem[1]  = 64'h2222222222222222;
    mem[2]  = 64'h3333333333333333;  mem[3]  = 64'h4444444444444444;
    mem[16] = 64'hAAAAAAAAAAAAAAAA;  mem[17] = 64'hBBBBBBBBBBBBBBBB;
    mem[18] = 64'hCCCCCCCCCCCCCCCC;  mem[19] = 64'hDDDDDDDDDDDDDDDD;

    //            flg   s0       s1       dst      n  tog   rst done1 done3
    recs[0] = '{1'b0, 9'h000, 9'h010, 9'h020, 4, 1'b0, 0, 11, 13};
    recs[1] = '{1'b1, 9'h000, 9'h010, 9'h020, 4, 1'b0, 0, 11, 13};
    recs[2] = '{1'b0, 9'h000, 9'h010, 9'h060, 0, 1'b0, 0,  1,  1};
    recs[3] = '{1'b1, 9'h000, 9'h010, 9'h030, 1, 1'b0, 0,  5,  7};
    recs[4] = '{1'b1, 9'h004, 9'h1FE, 9'h040, 3, 1'b0, 0,  9, 11};
    recs[5] = '{1'b0, 9'h100, 9'h000, 9'h050, 8, 1'b1, 0, 19, 21};
    recs[6] = '{1'b1, 9'h100, 9'h010, 9'h070, 8, 1'b0, 6, -1, -1};
    recs[7] = '{1'b0, 9'h003, 9'h1FE, 9'h080, 2, 1'b0, 0,  7,  9};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state_L1", 0, 128'({ra1, wa1, wd1, we1, busy1, done1}), 128'(0));
    check("reset_state_L3", 0, 128'({ra3, wa3, wd3, we3, busy3, done3}), 128'(0));
    @(posedge clk); #1;
    rst = 1'b1;

    for (int r = 0; r < 8; r++) begin
      cur = recs[r];
      for (int i = 0; i < cur.n; i++) begin
        e.a = cur.d + AW'(i);
        e.d = cur.flg ? mem[cur.s1 + AW'(i)] : mem[cur.s0 + AW'(i)];
        e.cyc = 2 * i + 4;
        if (cur.rst_at == 0 || e.cyc < cur.rst_at) q1.push_back(e);
        e.cyc = 2 * i + 6;
        if (cur.rst_at == 0 || e.cyc < cur.rst_at) q3.push_back(e);
      end
      @(posedge clk); #1;
      flag = cur.flg; src0_base = cur.s0; src1_base = cur.s1; dst_base = cur.d;
      word_count = CW'(cur.n); start = 1'b1;
      t0 = cyc; mon_on = 1'b1;
      len = (cur.rst_at != 0) ? cur.rst_at + 8 : 2 * cur.n + 8;
      for (int c = 1; c <= len; c++) begin
        @(posedge clk); #1;
        start = (cur.tog && (c % 3 == 0) && c <= 2 * cur.n);
        if (cur.tog && c <= 2 * cur.n) begin
          flag = ~flag;
          src0_base = src0_base + 9'd37;
          src1_base = src1_base ^ 9'h0F0;
          dst_base = ~dst_base;
          word_count = CW'(c);
        end
        if (cur.rst_at != 0 && c == cur.rst_at) rst = 1'b0;
        if (cur.rst_at != 0 && c == cur.rst_at + 2) rst = 1'b1;
      end
      @(posedge clk); #1;
      mon_on = 1'b0;
      check($sformatf("pending_writes_L1_rec%0d", r), len, 128'(q1.size()), 128'(0));
      check($sformatf("pending_writes_L3_rec%0d", r), len, 128'(q3.size()), 128'(0));
      check($sformatf("done_count_L1_rec%0d", r), len, 128'(dcnt1), 128'((cur.rst_at != 0) ? 0 : 1));
      check($sformatf("done_count_L3_rec%0d", r), len, 128'(dcnt3), 128'((cur.rst_at != 0) ? 0 : 1));
      q1.delete(); q3.delete();
      dcnt1 = 0; dcnt3 = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
